s_output_port_ctrl: RTL and testbench
=====================================

Name: s_output_port_ctrl

Overview:
- South output-port controller. Sits directly downstream of the south round-robin arbiter.
- Consumes the arbiter's one-hot grant (N/W/E/L) and locks the south crossbar path to the winning input for a whole packet (head through tail).
- Moves flits into a registered south link stage with a valid/ready handshake and pops the owning input buffer per flit.
- Pulses the arbiter's change-order input when a packet's tail leaves, so the round-robin rotates once per packet.

Parameters:
- FLIT_W, 32, flit width in bits; bit FLIT_W-1 = head, bit FLIT_W-2 = tail; both set = single-flit packet.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- rrp_s_priority_n_i  input  1  arbiter grant, north input
- rrp_s_priority_w_i  input  1  arbiter grant, west input
- rrp_s_priority_e_i  input  1  arbiter grant, east input
- rrp_s_priority_l_i  input  1  arbiter grant, local input
- n_flit_i / w_flit_i / e_flit_i / l_flit_i  input  FLIT_W each  head-of-queue flit of each input buffer
- n_valid_i / w_valid_i / e_valid_i / l_valid_i  input  1 each  buffer non-empty
- n_pop_o / w_pop_o / e_pop_o / l_pop_o  output  1 each  dequeue strobe, one cycle per flit taken
- s_flit_o  output  FLIT_W  registered flit toward the south link
- s_valid_o  output  1  s_flit_o holds a valid flit
- s_ready_i  input  1  downstream accepts the flit when s_valid_o && s_ready_i
- rr_register_change_order_o  output  1  one-cycle pulse to the arbiter at tail transfer
- s_busy_o  output  1  high while a packet is locked (state XFER)

Behaviour:
- Reset (async, any cycle, including mid-packet):
  - state=IDLE, owner=none, s_valid_o=0, s_flit_o=0.
  - All pops 0, rr_register_change_order_o=0, s_busy_o=0.
  - A partially sent packet is abandoned; the input buffers reset with it.
- Grant resolution:
  - Grant inputs are treated as one-hot.
  - If several are high, the fixed order N > W > E > L decides; the others are ignored.
- FSM, IDLE:
  - Lock condition: the resolved grant is set, its valid is high, and its flit has the head bit set.
  - On lock: latch the owner and go to XFER on the next edge. No pop in the latch cycle.
  - A grant on an input that is not valid, or whose flit is not a head, is ignored; stay in IDLE.
- FSM, XFER:
  - Grant inputs are ignored; the owner holds the path.
  - load = owner_valid && (!s_valid_o || s_ready_i).
  - On load: owner_pop_o=1 (combinational, same cycle); the owner flit is registered into s_flit_o at the edge and s_valid_o=1.
  - If the loaded flit has the tail bit: rr_register_change_order_o=1 that same cycle, then go to IDLE at the edge.
- Output stage:
  - If s_valid_o && s_ready_i && !load: s_valid_o clears next edge; s_flit_o keeps its last value.
  - If s_valid_o && !s_ready_i: s_flit_o and s_valid_o hold unchanged (stall); no pop.
  - Simultaneous drain and load give back-to-back flits with no bubble.
- Latency and throughput:
  - Grant seen in cycle t → owner latched at edge t → head popped in cycle t+1 → s_valid_o=1 from cycle t+2.
  - Steady state: 1 flit/cycle while s_ready_i=1 and the owner stays valid.
- Owner buffer empty mid-packet (owner valid=0): no pop; stay in XFER and wait. s_valid_o follows the output-stage rules.
- Single-flit packet (head and tail both set): latch cycle, then one XFER load with pop, change-order pulse, and return to IDLE.
- Back-to-back packets:
  - After the tail, IDLE re-evaluates grants the next cycle.
  - Minimum gap is one latch cycle between the tail load and the next head load.
- rr_register_change_order_o is never high for more than one consecutive cycle.
- At most one pop is high in any cycle.

Optional Feature:
- Macro: S_OUTPUT_PORT_STATS_EN.
- When defined, adds two ports:
  - s_pkt_count_o (output, 16): counts tail transfers.
  - s_stall_count_o (output, 16): counts cycles with s_valid_o && !s_ready_i.
- Both counters reset to 0 and wrap 0xFFFF→0x0000.
- When undefined, neither the ports nor the counters exist, and all other behaviour is identical.

Test Plan:
- Reset, then W grant with a 3-flit packet (head, body, tail), s_ready_i=1 → w_pop_o high for 3 consecutive cycles starting 1 cycle after the grant. s_flit_o shows the 3 flits in order from 2 cycles after the grant. One change-order pulse, coincident with the tail pop.
- N and L granted together, both holding single-flit packets → N served first (n_pop_o once, change-order once). L served only after a later L-only grant.
- Owner E mid-packet, s_ready_i=0 for 4 cycles → s_flit_o and s_valid_o stable and e_pop_o=0 for those cycles. Flow resumes with no flit lost or duplicated.
- Owner L, l_valid_i drops for 2 cycles mid-packet → s_busy_o stays 1, no pop, a new N grant is ignored, and the packet completes intact.
- Reset asserted asynchronously mid-packet (between clock edges) → all outputs 0 immediately. After release with a fresh grant, a new packet transfers normally.
- With S_OUTPUT_PORT_STATS_EN defined: 65537 single-flit packets → s_pkt_count_o=1. 5 stall cycles → s_stall_count_o=5.

Source files
------------

// File: rtl/s_output_port_ctrl.sv
// ---------------------------------------------------------------------------
// s_output_port_ctrl
//   South output-port controller. Takes the south round-robin arbiter's grant,
//   locks the south crossbar path to the winning input for a whole packet
//   (head through tail), moves flits into a registered south link stage with
//   a valid/ready handshake, pops the owning input buffer once per flit, and
//   pulses the arbiter's change-order input when the tail leaves.
//
//   Flit format: bit FLIT_W-1 = head, bit FLIT_W-2 = tail (both = 1-flit pkt).
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   rrp_s_priority_{n,w,e,l}_i      arbiter grant per input (one-hot expected)
//   {n,w,e,l}_flit_i                head-of-queue flit of each input buffer
//   {n,w,e,l}_valid_i               input buffer non-empty
//   {n,w,e,l}_pop_o                 dequeue strobe, one cycle per flit taken
//   s_flit_o / s_valid_o / s_ready_i  registered south link stage
//   rr_register_change_order_o      one-cycle pulse at tail transfer
//   s_busy_o                        high while a packet holds the path
//
// Optional build macro S_OUTPUT_PORT_STATS_EN adds:
//   s_pkt_count_o   (16) tail transfers, wrapping
//   s_stall_count_o (16) cycles with s_valid_o && !s_ready_i, wrapping
// ---------------------------------------------------------------------------
module s_output_port_ctrl #(
    parameter int FLIT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rrp_s_priority_n_i,
    input  logic              rrp_s_priority_w_i,
    input  logic              rrp_s_priority_e_i,
    input  logic              rrp_s_priority_l_i,
    input  logic [FLIT_W-1:0] n_flit_i,
    input  logic [FLIT_W-1:0] w_flit_i,
    input  logic [FLIT_W-1:0] e_flit_i,
    input  logic [FLIT_W-1:0] l_flit_i,
    input  logic              n_valid_i,
    input  logic              w_valid_i,
    input  logic              e_valid_i,
    input  logic              l_valid_i,
    output logic              n_pop_o,
    output logic              w_pop_o,
    output logic              e_pop_o,
    output logic              l_pop_o,
    output logic [FLIT_W-1:0] s_flit_o,
    output logic              s_valid_o,
    input  logic              s_ready_i,
    output logic              rr_register_change_order_o,
    output logic              s_busy_o
`ifdef S_OUTPUT_PORT_STATS_EN
    ,
    output logic [15:0]       s_pkt_count_o,
    output logic [15:0]       s_stall_count_o
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_N = 2'd0,
        OWN_W = 2'd1,
        OWN_E = 2'd2,
        OWN_L = 2'd3
    } owner_t;

    state_t              r_state;
    state_t              w_state_nxt;
    owner_t              r_owner;
    owner_t              w_gnt_sel;
    logic                w_gnt_any;
    logic                w_gnt_valid;
    logic [FLIT_W-1:0]   w_gnt_flit;
    logic                w_own_valid;
    logic [FLIT_W-1:0]   w_own_flit;
    logic                w_lock;
    logic                w_load;
    logic                w_tail_xfer;
    logic [3:0]          w_pop;      // {L,E,W,N}
    logic [FLIT_W-1:0]   r_s_flit;
    logic                r_s_valid;

    // Grant resolution: fixed N > W > E > L if the arbiter ever raises more
    // than one grant.
    always_comb begin
        w_gnt_sel = OWN_N;
        w_gnt_any = 1'b1;
        if (rrp_s_priority_n_i)      w_gnt_sel = OWN_N;
        else if (rrp_s_priority_w_i) w_gnt_sel = OWN_W;
        else if (rrp_s_priority_e_i) w_gnt_sel = OWN_E;
        else if (rrp_s_priority_l_i) w_gnt_sel = OWN_L;
        else                         w_gnt_any = 1'b0;
    end

    // Valid/flit of the resolved grant (used only for locking in IDLE).
    always_comb begin
        w_gnt_valid = n_valid_i;
        w_gnt_flit  = n_flit_i;
        case (w_gnt_sel)
            OWN_N: begin w_gnt_valid = n_valid_i; w_gnt_flit = n_flit_i; end
            OWN_W: begin w_gnt_valid = w_valid_i; w_gnt_flit = w_flit_i; end
            OWN_E: begin w_gnt_valid = e_valid_i; w_gnt_flit = e_flit_i; end
            OWN_L: begin w_gnt_valid = l_valid_i; w_gnt_flit = l_flit_i; end
            default: ;
        endcase
    end

    // Valid/flit of the latched owner (crossbar path while in XFER).
    always_comb begin
        w_own_valid = n_valid_i;
        w_own_flit  = n_flit_i;
        case (r_owner)
            OWN_N: begin w_own_valid = n_valid_i; w_own_flit = n_flit_i; end
            OWN_W: begin w_own_valid = w_valid_i; w_own_flit = w_flit_i; end
            OWN_E: begin w_own_valid = e_valid_i; w_own_flit = e_flit_i; end
            OWN_L: begin w_own_valid = l_valid_i; w_own_flit = l_flit_i; end
            default: ;
        endcase
    end

    // Only a valid head flit on the granted input can open a packet.
    assign w_lock = (r_state == ST_IDLE) && w_gnt_any && w_gnt_valid &&
                    w_gnt_flit[FLIT_W-1];

    // FSM next-state and per-flit control
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_tail_xfer = 1'b0;
        w_pop       = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (w_lock) w_state_nxt = ST_XFER;
            end
            ST_XFER: begin
                // Load when the output stage is empty or draining this cycle.
                if (w_own_valid && (!r_s_valid || s_ready_i)) begin
                    w_load           = 1'b1;
                    w_pop[r_owner]   = 1'b1;
                    if (w_own_flit[FLIT_W-2]) begin
                        w_tail_xfer = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_N;
        end else begin
            r_state <= w_state_nxt;
            if (w_lock) r_owner <= w_gnt_sel;
        end
    end

    // South link register stage. s_flit_o keeps its last value after drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_flit  <= '0;
            r_s_valid <= 1'b0;
        end else if (w_load) begin
            r_s_flit  <= w_own_flit;
            r_s_valid <= 1'b1;
        end else if (r_s_valid && s_ready_i) begin
            r_s_valid <= 1'b0;
        end
    end

`ifdef S_OUTPUT_PORT_STATS_EN
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_cnt   <= 16'h0000;
            r_stall_cnt <= 16'h0000;
        end else begin
            if (w_tail_xfer)             r_pkt_cnt   <= r_pkt_cnt + 16'h0001;
            if (r_s_valid && !s_ready_i) r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign s_pkt_count_o   = r_pkt_cnt;
    assign s_stall_count_o = r_stall_cnt;
`endif

    assign n_pop_o                    = w_pop[0];
    assign w_pop_o                    = w_pop[1];
    assign e_pop_o                    = w_pop[2];
    assign l_pop_o                    = w_pop[3];
    assign s_flit_o                   = r_s_flit;
    assign s_valid_o                  = r_s_valid;
    assign rr_register_change_order_o = w_tail_xfer;
    assign s_busy_o                   = (r_state == ST_XFER);

endmodule

// File: tb/tb_s_output_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_s_output_port_ctrl
//   Directed table of per-cycle {inputs, expected outputs} for the south
//   output-port controller, followed by a hand-written async-reset / stall
//   sequence. Inputs change 1 time unit after the rising edge; outputs are
//   compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_s_output_port_ctrl;

    localparam int FW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          gn, gw, ge, gl;
    logic [FW-1:0] nf, wf, ef, lf;
    logic          nv, wv, ev, lv;
    logic          np, wp, ep, lp;
    logic [FW-1:0] s_flit;
    logic          s_valid;
    logic          s_ready;
    logic          co;
    logic          busy;
`ifdef S_OUTPUT_PORT_STATS_EN
    logic [15:0]   pkt_cnt;
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    s_output_port_ctrl #(.FLIT_W(FW)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .rrp_s_priority_n_i         (gn),
        .rrp_s_priority_w_i         (gw),
        .rrp_s_priority_e_i         (ge),
        .rrp_s_priority_l_i         (gl),
        .n_flit_i                   (nf),
        .w_flit_i                   (wf),
        .e_flit_i                   (ef),
        .l_flit_i                   (lf),
        .n_valid_i                  (nv),
        .w_valid_i                  (wv),
        .e_valid_i                  (ev),
        .l_valid_i                  (lv),
        .n_pop_o                    (np),
        .w_pop_o                    (wp),
        .e_pop_o                    (ep),
        .l_pop_o                    (lp),
        .s_flit_o                   (s_flit),
        .s_valid_o                  (s_valid),
        .s_ready_i                  (s_ready),
        .rr_register_change_order_o (co),
        .s_busy_o                   (busy)
`ifdef S_OUTPUT_PORT_STATS_EN
        ,
        .s_pkt_count_o              (pkt_cnt),
        .s_stall_count_o            (stall_cnt)
`endif
    );

    // gnt/vld/pop bit order: {N, W, E, L}
    typedef struct {
        logic [3:0]    gnt;
        logic [3:0]    vld;
        logic [FW-1:0] nf, wf, ef, lf;
        logic          rdy;
        logic [3:0]    pop;
        logic          sv;
        logic [FW-1:0] sf;
        logic          co;
        logic          busy;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    localparam logic [FW-1:0] Z   = 32'h0000_0000;
    localparam logic [FW-1:0] WH  = 32'h8000_0011, WB = 32'h0000_0012, WT = 32'h4000_0013;
    localparam logic [FW-1:0] NS  = 32'hC000_0021, LS = 32'hC000_0031;
    localparam logic [FW-1:0] EH  = 32'h8000_0041, EB1 = 32'h0000_0042;
    localparam logic [FW-1:0] EB2 = 32'h0000_0043, ET = 32'h4000_0044;
    localparam logic [FW-1:0] LH  = 32'h8000_0051, LB = 32'h0000_0052, LT = 32'h4000_0053;
    localparam logic [FW-1:0] NH  = 32'h8000_0061, NB = 32'h0000_0062;
    localparam logic [FW-1:0] WS  = 32'hC000_0071;

    function automatic vec_t mkv(input logic [3:0] g, input logic [3:0] v,
                                 input logic [FW-1:0] f_n, input logic [FW-1:0] f_w,
                                 input logic [FW-1:0] f_e, input logic [FW-1:0] f_l,
                                 input logic r, input logic [3:0] p, input logic x_sv,
                                 input logic [FW-1:0] x_sf, input logic x_co,
                                 input logic x_busy);
        vec_t t;
        t.gnt = g;  t.vld = v;
        t.nf = f_n; t.wf = f_w; t.ef = f_e; t.lf = f_l;
        t.rdy = r;  t.pop = p;  t.sv = x_sv; t.sf = x_sf;
        t.co = x_co; t.busy = x_busy;
        return t;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        {gn, gw, ge, gl} = 4'b0000;
        {nv, wv, ev, lv} = 4'b0000;
        nf = Z; wf = Z; ef = Z; lf = Z;
        s_ready = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        {gn, gw, ge, gl} = v.gnt;
        {nv, wv, ev, lv} = v.vld;
        nf = v.nf; wf = v.wf; ef = v.ef; lf = v.lf;
        s_ready = v.rdy;
        #4;
        chk("pop",   idx, {28'd0, np, wp, ep, lp}, {28'd0, v.pop});
        chk("valid", idx, {31'd0, s_valid}, {31'd0, v.sv});
        chk("flit",  idx, s_flit, v.sf);
        chk("chord", idx, {31'd0, co}, {31'd0, v.co});
        chk("busy",  idx, {31'd0, busy}, {31'd0, v.busy});
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_pop"},   0, {28'd0, np, wp, ep, lp}, 32'd0);
        chk({name, "_valid"}, 0, {31'd0, s_valid}, 32'd0);
        chk({name, "_flit"},  0, s_flit, Z);
        chk({name, "_chord"}, 0, {31'd0, co}, 32'd0);
        chk({name, "_busy"},  0, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // W 3-flit packet, ready high
        vq.push_back(mkv(4'b0100, 4'b0100, Z, WH, Z, Z, 1, 4'b0000, 0, Z,  0, 0));
        vq.push_back(mkv(4'b0000, 4'b0100, Z, WH, Z, Z, 1, 4'b0100, 0, Z,  0, 1));
        vq.push_back(mkv(4'b0000, 4'b0100, Z, WB, Z, Z, 1, 4'b0100, 1, WH, 0, 1));
        vq.push_back(mkv(4'b0000, 4'b0100, Z, WT, Z, Z, 1, 4'b0100, 1, WB, 1, 1));
        vq.push_back(mkv(4'b0000, 4'b0000, Z, Z,  Z, Z, 1, 4'b0000, 1, WT, 0, 0));
        vq.push_back(mkv(4'b0000, 4'b0000, Z, Z,  Z, Z, 1, 4'b0000, 0, WT, 0, 0));
        // N and L granted together: N wins; L only after its own grant
        vq.push_back(mkv(4'b1001, 4'b1001, NS, Z, Z, LS, 1, 4'b0000, 0, WT, 0, 0));
        vq.push_back(mkv(4'b0000, 4'b1001, NS, Z, Z, LS, 1, 4'b1000, 0, WT, 1, 1));
        vq.push_back(mkv(4'b0000, 4'b0001, Z,  Z, Z, LS, 1, 4'b0000, 1, NS, 0, 0));
        vq.push_back(mkv(4'b0001, 4'b0001, Z,  Z, Z, LS, 1, 4'b0000, 0, NS, 0, 0));
        vq.push_back(mkv(4'b0000, 4'b0001, Z,  Z, Z, LS, 1, 4'b0001, 0, NS, 1, 1));
        vq.push_back(mkv(4'b0000, 4'b0000, Z,  Z, Z, Z,  1, 4'b0000, 1, LS, 0, 0));
        // Grant on an empty input, then on a non-head flit: both ignored
        vq.push_back(mkv(4'b0010, 4'b0000, Z, Z, EB1, Z, 1, 4'b0000, 0, LS, 0, 0));
        vq.push_back(mkv(4'b0010, 4'b0010, Z, Z, EB1, Z, 1, 4'b0000, 0, LS, 0, 0));
        vq.push_back(mkv(4'b0000, 4'b0000, Z, Z, Z,   Z, 1, 4'b0000, 0, LS, 0, 0));
        // E 4-flit packet with a 4-cycle downstream stall
        vq.push_back(mkv(4'b0010, 4'b0010, Z, Z, EH,  Z, 1, 4'b0000, 0, LS,  0, 0));
        vq.push_back(mkv(4'b0000, 4'b0010, Z, Z, EH,  Z, 1, 4'b0010, 0, LS,  0, 1));
        vq.push_back(mkv(4'b0000, 4'b0010, Z, Z, EB1, Z, 1, 4'b0010, 1, EH,  0, 1));
        for (int i = 0; i < 4; i++)
            vq.push_back(mkv(4'b0000, 4'b0010, Z, Z, EB2, Z, 0, 4'b0000, 1, EB1, 0, 1));
        vq.push_back(mkv(4'b0000, 4'b0010, Z, Z, EB2, Z, 1, 4'b0010, 1, EB1, 0, 1));
        vq.push_back(mkv(4'b0000, 4'b0010, Z, Z, ET,  Z, 1, 4'b0010, 1, EB2, 1, 1));
        vq.push_back(mkv(4'b0000, 4'b0000, Z, Z, Z,   Z, 1, 4'b0000, 1, ET,  0, 0));
        vq.push_back(mkv(4'b0000, 4'b0000, Z, Z, Z,   Z, 1, 4'b0000, 0, ET,  0, 0));
        // L packet with a 2-cycle empty buffer; an N grant meanwhile is ignored
        vq.push_back(mkv(4'b0001, 4'b0001, Z,  Z, Z, LH, 1, 4'b0000, 0, ET, 0, 0));
        vq.push_back(mkv(4'b0000, 4'b0001, Z,  Z, Z, LH, 1, 4'b0001, 0, ET, 0, 1));
        vq.push_back(mkv(4'b1000, 4'b1000, NH, Z, Z, LB, 1, 4'b0000, 1, LH, 0, 1));
        vq.push_back(mkv(4'b1000, 4'b1000, NH, Z, Z, LB, 1, 4'b0000, 0, LH, 0, 1));
        vq.push_back(mkv(4'b1000, 4'b1001, NH, Z, Z, LB, 1, 4'b0001, 0, LH, 0, 1));
        vq.push_back(mkv(4'b0000, 4'b0001, Z,  Z, Z, LT, 1, 4'b0001, 1, LB, 1, 1));
        vq.push_back(mkv(4'b0000, 4'b0000, Z,  Z, Z, Z,  1, 4'b0000, 1, LT, 0, 0));
        vq.push_back(mkv(4'b0000, 4'b0000, Z,  Z, Z, Z,  1, 4'b0000, 0, LT, 0, 0));

        // Reset state
        reset = 1'b1;
        drive_idle();
        #2;
        chk_all_zero("rst");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vq[i]) apply_vec(vq[i], i);

        // Async reset in the middle of an N packet, between clock edges
        @(posedge clk); #1;
        drive_idle();
        gn = 1'b1; nv = 1'b1; nf = NH;
        @(posedge clk); #1;
        gn = 1'b0;                               // head popped this cycle
        @(posedge clk); #1;
        nf = NB;                                 // body would pop now
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("arst");
        @(posedge clk); #1;
        reset = 1'b0;
        drive_idle();

        // Fresh single-flit W packet after reset, then a 5-cycle stall
        @(posedge clk); #1;
        gw = 1'b1; wv = 1'b1; wf = WS;
        #4;
        chk("post_pop0",  0, {28'd0, np, wp, ep, lp}, 32'd0);
        chk("post_busy0", 0, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        gw = 1'b0;
        #4;
        chk("post_pop1",  0, {28'd0, np, wp, ep, lp}, 32'h4);
        chk("post_chord", 0, {31'd0, co}, 32'd1);
        chk("post_busy1", 0, {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            wv = 1'b0; s_ready = 1'b0;
            #4;
            chk("stall_valid", i, {31'd0, s_valid}, 32'd1);
            chk("stall_flit",  i, s_flit, WS);
            chk("stall_busy",  i, {31'd0, busy}, 32'd0);
        end
        @(posedge clk); #1;
        s_ready = 1'b1;
        #4;
        chk("drain_valid", 0, {31'd0, s_valid}, 32'd1);
`ifdef S_OUTPUT_PORT_STATS_EN
        chk("pkt_cnt",   0, {16'd0, pkt_cnt},   32'd1);
        chk("stall_cnt", 0, {16'd0, stall_cnt}, 32'd5);
`endif
        @(posedge clk); #1;
        #4;
        chk("drained_valid", 0, {31'd0, s_valid}, 32'd0);
        chk("drained_flit",  0, s_flit, WS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
